// File: rtl/iir_filter_pkg.sv
// Shared widths, FSM state type and saturation helper for the IIR inverse filter.
package iir_filter_pkg;

  localparam int NB_DATA_IN_DEF  = 12;
  localparam int NB_DATA_OUT_DEF = 8;
  localparam int NB_ACC_DEF      = NB_DATA_IN_DEF + 4;
  localparam int SAT_COUNT_MAX   = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  // Clamp a sign-extended accumulator value to the signed range of nb_out bits.
  // Works on a 32-bit carrier so one function serves any NB_ACC up to 32.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                  input int nb_out);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (nb_out - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (nb_out - 1));
    if (val > hi)      return hi;
    else if (val < lo) return lo;
    else               return val;
  endfunction

endpackage

// File: rtl/iir_sat_monitor.sv
// Sticky saturation flag plus an 8-bit event counter that holds at its max.
module iir_sat_monitor
  import iir_filter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       hit,
  output logic       sat,
  output logic [7:0] count
);

  // Flag latches on first hit; counter stops at SAT_COUNT_MAX instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat   <= 1'b0;
      count <= 8'd0;
    end else if (clear) begin
      sat   <= 1'b0;
      count <= 8'd0;
    end else if (hit) begin
      sat <= 1'b1;
      if (count != 8'(SAT_COUNT_MAX)) count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/iir_inverse_filter.sv
// Inverse of the 2nd-order IIR filter: FIR on the denominator, recursion on the
// numerator, saturated registered output behind a valid/ready handshake.
module iir_inverse_filter
  import iir_filter_pkg::*;
#(
  parameter int NB_DATA_IN  = NB_DATA_IN_DEF,
  parameter int NB_DATA_OUT = NB_DATA_OUT_DEF,
  parameter int NB_ACC      = NB_DATA_IN + 4,
  parameter int SKIP_PRIME  = 0
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_clear,
  input  logic signed [NB_DATA_IN-1:0]  i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic signed [NB_DATA_OUT-1:0] o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_sat,
  output logic [7:0]                    o_sat_count
);

  state_t state_q, state_d;

  logic signed [NB_DATA_IN-1:0]  y_d1, y_d2;
  logic signed [NB_DATA_OUT-1:0] x_d1, x_d2;

  logic signed [NB_ACC-1:0]      y_cur, y_h1, y_h2, x_h1, x_h2, v, x_sum;
  logic signed [31:0]            x_wide;
  logic signed [NB_DATA_OUT-1:0] x_sat;
  logic                          sat_hit, accept, take_in, load;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  // A clear in the same cycle drops the incoming sample entirely.
  assign take_in = accept && !i_clear;
  // Priming results are still computed (zero history) but hidden when SKIP_PRIME=1.
  assign load    = take_in && ((SKIP_PRIME == 0) || (state_q == ST_RUN));

  // Everything is widened to NB_ACC so neither sum can wrap.
  assign y_cur   = NB_ACC'(i_data);
  assign y_h1    = NB_ACC'(y_d1);
  assign y_h2    = NB_ACC'(y_d2);
  assign x_h1    = NB_ACC'(x_d1);
  assign x_h2    = NB_ACC'(x_d2);
  assign v       = y_cur - (y_h1 >>> 1) - (y_h2 >>> 1);
  assign x_sum   = v + x_h1 - x_h2;
  assign x_wide  = saturate(32'(x_sum), NB_DATA_OUT);
  assign x_sat   = NB_DATA_OUT'(x_wide);
  assign sat_hit = (x_wide != 32'(x_sum));

  // Sample history: only accepted samples shift in; x history keeps saturated values.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      y_d1 <= '0;
      y_d2 <= '0;
      x_d1 <= '0;
      x_d2 <= '0;
    end else if (i_clear) begin
      y_d1 <= '0;
      y_d2 <= '0;
      x_d1 <= '0;
      x_d2 <= '0;
    end else if (take_in) begin
      y_d1 <= i_data;
      y_d2 <= y_d1;
      x_d1 <= x_sat;
      x_d2 <= x_d1;
    end
  end

  // Output register: new result overwrites, otherwise drops valid when taken.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= x_sat;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Priming FSM state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Priming FSM next state: count two accepted samples of history, then run.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  iir_sat_monitor u_sat_monitor (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .clear (i_clear),
    .hit   (load && sat_hit),
    .sat   (o_sat),
    .count (o_sat_count)
  );

endmodule

// File: tb/tb_iir_inverse_filter.sv
// Directed and model-based bench for iir_inverse_filter (SKIP_PRIME 0 and 1).
module tb_iir_inverse_filter;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              out_ready;
  logic signed [11:0] in_data;

  logic              rdy0, vld0, sat0;
  logic              rdy1, vld1, sat1;
  logic signed [7:0] dat0, dat1;
  logic [7:0]        cnt0, cnt1;

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iir_inverse_filter #(.SKIP_PRIME(0)) dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(clear),
    .i_data(in_data), .i_valid(in_valid), .o_ready(rdy0),
    .o_data(dat0), .o_valid(vld0), .i_ready(out_ready),
    .o_sat(sat0), .o_sat_count(cnt0)
  );

  iir_inverse_filter #(.SKIP_PRIME(1)) dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(clear),
    .i_data(in_data), .i_valid(in_valid), .o_ready(rdy1),
    .o_data(dat1), .o_valid(vld1), .i_ready(out_ready),
    .o_sat(sat1), .o_sat_count(cnt1)
  );

  task automatic drive(input int y, input logic v, input logic r);
    @(negedge clk);
    in_data   = 12'(y);
    in_valid  = v;
    out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vld0); end
    total++; if (dat0 !== 8'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", dat0); end
    total++; if (sat0 !== 1'b0 || cnt0 !== 8'd0) begin bad++; $display("FAIL reset_sat got=%b/%0d want=0/0", sat0, cnt0); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", rdy0); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    drive(16, 1'b1, 1'b1);
    #1;
    total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL stream_latency got=%b want=0", vld0); end
    step();
    total++; if (vld0 !== 1'b1 || dat0 !== 8'sd16) begin bad++; $display("FAIL stream_x0 got=%b/%0d want=1/16", vld0, dat0); end
    drive(0, 1'b1, 1'b1); step();
    total++; if (dat0 !== 8'sd8) begin bad++; $display("FAIL stream_x1 got=%0d want=8", dat0); end
    drive(0, 1'b1, 1'b1); step();
    total++; if (dat0 !== 8'(-16)) begin bad++; $display("FAIL stream_x2 got=%0d want=-16", dat0); end
    total++; if (sat0 !== 1'b0) begin bad++; $display("FAIL stream_nosat got=%b want=0", sat0); end
    drive(0, 1'b0, 1'b1); step();
    total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", vld0); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(200, 1'b1, 1'b1); step();
    total++; if (dat0 !== 8'sd127) begin bad++; $display("FAIL sat_pos got=%0d want=127", dat0); end
    total++; if (sat0 !== 1'b1 || cnt0 !== 8'd1) begin bad++; $display("FAIL sat_cnt1 got=%b/%0d want=1/1", sat0, cnt0); end
    drive(-300, 1'b1, 1'b1); step();
    total++; if (dat0 !== 8'(-128)) begin bad++; $display("FAIL sat_neg got=%0d want=-128", dat0); end
    total++; if (cnt0 !== 8'd2) begin bad++; $display("FAIL sat_cnt2 got=%0d want=2", cnt0); end
    drive(0, 1'b0, 1'b1); step();
  endtask

  // Clear wins over a same-cycle accept and wipes the saturation monitor.
  task automatic test_clear();
    drive(16, 1'b1, 1'b1); clear = 1'b1; step();
    total++; if (vld0 !== 1'b0 || dat0 !== 8'd0) begin bad++; $display("FAIL clear_out got=%b/%0d want=0/0", vld0, dat0); end
    total++; if (sat0 !== 1'b0 || cnt0 !== 8'd0) begin bad++; $display("FAIL clear_sat got=%b/%0d want=0/0", sat0, cnt0); end
    drive(0, 1'b1, 1'b1); clear = 1'b0; step();
    total++; if (vld0 !== 1'b1 || dat0 !== 8'd0) begin bad++; $display("FAIL clear_drop got=%b/%0d want=1/0", vld0, dat0); end
    drive(0, 1'b0, 1'b1); step();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(16, 1'b1, 1'b1); step();
    drive(0, 1'b1, 1'b0);
    #1;
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", rdy0); end
    repeat (5) begin
      step();
      total++; if (vld0 !== 1'b1 || dat0 !== 8'sd16) begin bad++; $display("FAIL bp_hold got=%b/%0d want=1/16", vld0, dat0); end
    end
    drive(0, 1'b1, 1'b1); step();
    total++; if (vld0 !== 1'b1 || dat0 !== 8'sd8) begin bad++; $display("FAIL bp_resume1 got=%b/%0d want=1/8", vld0, dat0); end
    drive(0, 1'b1, 1'b1); step();
    total++; if (dat0 !== 8'(-16)) begin bad++; $display("FAIL bp_resume2 got=%0d want=-16", dat0); end
    drive(0, 1'b0, 1'b1); step();
    total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", vld0); end
  endtask

  task automatic test_skip_prime();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      drive(16, 1'b1, 1'b1); clear = 1'b0; step();
      total++; if (vld1 !== 1'b0) begin bad++; $display("FAIL skip_p%0d_a got=%b want=0", pass, vld1); end
      drive(0, 1'b1, 1'b1); step();
      total++; if (vld1 !== 1'b0) begin bad++; $display("FAIL skip_p%0d_b got=%b want=0", pass, vld1); end
      drive(0, 1'b1, 1'b1); step();
      total++; if (vld1 !== 1'b1 || dat1 !== 8'(-16)) begin bad++; $display("FAIL skip_p%0d_c got=%b/%0d want=1/-16", pass, vld1, dat1); end
      total++; if (sat1 !== 1'b0) begin bad++; $display("FAIL skip_p%0d_sat got=%b want=0", pass, sat1); end
      drive(0, 1'b0, 1'b1); clear = 1'b1; step();
    end
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(200, 1'b1, 1'b1); step();
    drive(0, 1'b0, 1'b0);
    #2; rst_n = 1'b0; #1;
    total++; if (vld0 !== 1'b0 || dat0 !== 8'd0) begin bad++; $display("FAIL areset_out got=%b/%0d want=0/0", vld0, dat0); end
    total++; if (sat0 !== 1'b0 || cnt0 !== 8'd0) begin bad++; $display("FAIL areset_sat got=%b/%0d want=0/0", sat0, cnt0); end
    @(negedge clk); rst_n = 1'b1;
    drive(16, 1'b1, 1'b1); step();
    total++; if (vld0 !== 1'b1 || dat0 !== 8'sd16) begin bad++; $display("FAIL areset_after got=%b/%0d want=1/16", vld0, dat0); end
    drive(0, 1'b0, 1'b1); step();
  endtask

  // Forward filter model feeds the DUT; recovered samples must equal the originals.
  task automatic test_random();
    int xs[24];
    int ys[24];
    int y1, y2, x1, x2, v;
    int in_idx, out_idx, cyc;
    logic acc, take;
    y1 = 0; y2 = 0; x1 = 0; x2 = 0;
    for (int i = 0; i < 24; i++) begin
      xs[i] = int'($urandom_range(20)) - 10;
      v     = xs[i] - x1 + x2;
      ys[i] = v + (y1 >>> 1) + (y2 >>> 1);
      x2 = x1; x1 = xs[i];
      y2 = y1; y1 = ys[i];
    end
    do_reset();
    in_idx = 0; out_idx = 0; cyc = 0;
    while (out_idx < 24 && cyc < 2000) begin
      @(negedge clk);
      in_valid  = (in_idx < 24) && ($urandom_range(3) != 0);
      in_data   = 12'(ys[(in_idx < 24) ? in_idx : 23]);
      out_ready = ($urandom_range(2) != 0);
      #1;
      acc  = in_valid && rdy0;
      take = vld0 && out_ready;
      if (take) begin
        total++;
        if (dat0 !== 8'(xs[out_idx])) begin bad++; $display("FAIL rand_x%0d got=%0d want=%0d", out_idx, dat0, xs[out_idx]); end
        out_idx++;
      end
      @(posedge clk);
      if (acc) in_idx++;
      cyc++;
    end
    if (out_idx < 24) begin
      total++; bad++;
      $display("FAIL rand_timeout got=%0d outputs want=24", out_idx);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_saturation();
    test_clear();
    test_backpressure();
    test_skip_prime();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iir_inverse_filter.md
Name: iir_inverse_filter

Overview:
- Inverse (decoder) of the team's 2nd-order IIR filter: recovers the 8-bit input stream from the 12-bit filtered stream.
- Sits at the receive end of a filter link, or in a loopback test path behind the IIR filter.
- The filter's denominator is applied as an FIR: v[n] = y[n] - (y[n-1]>>>1) - (y[n-2]>>>1).
- The filter's numerator is inverted recursively: x[n] = v[n] + x[n-1] - x[n-2].
- Streaming valid/ready handshake on both sides, registered output, priming state machine, saturation monitor.

Parameters:
- NB_DATA_IN, 12, width of filtered input sample y (signed).
- NB_DATA_OUT, 8, width of recovered sample x (signed).
- NB_ACC, NB_DATA_IN+4, internal accumulator width (signed).
- SKIP_PRIME, 0, when 1 suppresses output until two history samples have been accepted.

Ports:
- i_clock  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous clear of history, state and counters (outputs as after reset).
- i_data  in  NB_DATA_IN  filtered sample y[n], signed.
- i_valid  in  1  i_data valid.
- o_ready  out  1  block can accept a sample.
- o_data  out  NB_DATA_OUT  recovered sample x[n], signed, registered.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts o_data.
- o_sat  out  1  sticky: some output saturated since last reset/clear.
- o_sat_count  out  8  number of saturated outputs, holds at 255.

Behaviour:
- Reset (async assert, sync deassert handled externally): o_data=0, o_valid=0, o_sat=0, o_sat_count=0, y/x history=0, state=IDLE. o_ready is combinational and equals 1 after reset.
- o_ready = !o_valid || i_ready. Accept = i_valid && o_ready. Only accepted samples advance the history.
- Arithmetic: sign-extend everything to NB_ACC. The >>>1 is an arithmetic shift (floor). v and the pre-saturation x sum are computed at NB_ACC, so no wrap is possible.
- Saturation: x is saturated to [-2^(NB_DATA_OUT-1), 2^(NB_DATA_OUT-1)-1]. History x[n-1] and x[n-2] store the saturated value.
- Latency: o_data/o_valid are registered 1 cycle after the accept edge.
- Output hold: while o_valid=1 and i_ready=0, o_data stays stable.
- Simultaneous accept and downstream take: the new result replaces the old one in the same cycle. Full throughput is 1 sample/clock.
- State machine states: IDLE (no history), PRIME (1 sample), RUN.
  - IDLE to PRIME on accept.
  - PRIME to RUN on accept.
  - RUN holds.
  - i_clear forces IDLE from any state.
- SKIP_PRIME=1: accepts in IDLE/PRIME update history but do not set o_valid.
- SKIP_PRIME=0: every accept produces an output, using zero history.
- Saturation monitor: o_sat and o_sat_count update only when a saturated result is loaded into the output register. Suppressed prime results are not counted.
- i_clear: takes priority over a same-cycle accept (the sample is dropped). It zeroes history, o_valid, o_data, o_sat and o_sat_count.
- Reset mid-stream: any pending o_valid is lost; no output glitch beyond going to 0.

Decomposition:
- Package iir_filter_pkg holds:
  - default widths;
  - state enum typedef (ST_IDLE, ST_PRIME, ST_RUN);
  - a saturate function (NB_ACC to NB_DATA_OUT);
  - SAT_COUNT_MAX = 255.
- One sub-module, iir_sat_monitor: sticky flag plus saturating 8-bit counter, with clear. The datapath and FSM stay in the top module.

Test Plan:
- SKIP_PRIME=0, reset, stream y=16,0,0 with i_ready=1 -> o_data=16,8,-16, each 1 cycle after accept; o_sat=0.
- Single sample y=200 -> o_data=127, o_sat=1, o_sat_count=1; then y=-300 (accumulates negatively) -> o_data=-128, count=2.
- Backpressure: o_valid=1, hold i_ready=0 for 5 cycles while i_valid=1 -> o_ready=0, o_data stable, history not advanced; release -> sequence continues without loss or duplication.
- SKIP_PRIME=1, y=16,0,0 -> first two accepts give no o_valid, third gives o_data=-16; pulse i_clear -> state IDLE, next two accepts again suppressed.
- Assert i_reset_n low mid-stream with o_valid=1 -> o_valid, o_data, o_sat and o_sat_count go 0 immediately (async); after release, y=16 -> o_data=16.
- Random y stream through a reference IIR filter model, then this block, with random i_valid/i_ready -> recovered x equals original x for inputs that never saturate.
